// File: rtl/wb_sequencer.sv
// Writeback sequencer: merges ALU results (through a 2-entry in-order FIFO) and a single
// outstanding memory load into one registered register-file write port, and reports
// read-after-write hazards for two decode-stage source registers.
module wb_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alu_valid,
    input  logic [3:0] alu_dest,
    input  logic [7:0] alu_data,
    output logic       alu_ready,
    input  logic       mem_req,
    input  logic [3:0] mem_dest,
    output logic       mem_ready,
    input  logic       mem_rvalid,
    input  logic [7:0] mem_rdata,
    input  logic [3:0] query_a,
    input  logic [3:0] query_b,
    output logic       hazard_a,
    output logic       hazard_b,
    output logic       RegWrite,
    output logic [3:0] destination,
    output logic [7:0] write_data,
    output logic       err
);

    typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pend_dest_q, pend_dest_d;

    logic [3:0]  fifo_dest_q [2];
    logic [7:0]  fifo_data_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;

    logic        reg_write_q;
    logic [3:0]  dest_q;
    logic [7:0]  data_q;
    logic        err_q;

    logic        alu_fire, load_wr, fifo_pop, bypass, push;
    logic        wr_en;
    logic [3:0]  wr_dest;
    logic [7:0]  wr_data;

    // Load tracking FSM: next state and pending destination capture
    always_comb begin
        state_d     = state_q;
        pend_dest_d = pend_dest_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    state_d     = StWaitMem;
                    pend_dest_d = mem_dest;
                end
            end
            StWaitMem: begin
                if (mem_rvalid) state_d = StIdle;
            end
        endcase
    end

    // Handshakes, write arbitration and FIFO bookkeeping
    always_comb begin
        mem_ready = (state_q == StIdle);
        // Stall ALU writes to the pending load's register so the load cannot overwrite them
        alu_ready = (count_q != 2'd2) && !((state_q == StWaitMem) && (alu_dest == pend_dest_q));
        alu_fire  = alu_valid && alu_ready;
        load_wr   = (state_q == StWaitMem) && mem_rvalid;
        fifo_pop  = !load_wr && (count_q != 2'd0);
        // Empty FIFO and no load write: the ALU result goes straight to the output register
        bypass    = !load_wr && (count_q == 2'd0) && alu_fire;
        push      = alu_fire && !bypass;
        count_d   = count_q + {1'b0, push} - {1'b0, fifo_pop};

        wr_en   = 1'b0;
        wr_dest = dest_q;
        wr_data = data_q;
        if (load_wr) begin
            wr_en   = 1'b1;
            wr_dest = pend_dest_q;
            wr_data = mem_rdata;
        end else if (fifo_pop) begin
            wr_en   = 1'b1;
            wr_dest = fifo_dest_q[rd_ptr_q];
            wr_data = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            wr_en   = 1'b1;
            wr_dest = alu_dest;
            wr_data = alu_data;
        end
    end

    // Hazard detection: pending load, valid FIFO entries, and the write on the output port
    always_comb begin
        hazard_a = ((state_q == StWaitMem) && (query_a == pend_dest_q))
                || ((count_q != 2'd0) && (query_a == fifo_dest_q[rd_ptr_q]))
                || ((count_q == 2'd2) && (query_a == fifo_dest_q[~rd_ptr_q]))
                || (reg_write_q && (query_a == dest_q));
        hazard_b = ((state_q == StWaitMem) && (query_b == pend_dest_q))
                || ((count_q != 2'd0) && (query_b == fifo_dest_q[rd_ptr_q]))
                || ((count_q == 2'd2) && (query_b == fifo_dest_q[~rd_ptr_q]))
                || (reg_write_q && (query_b == dest_q));
    end

    // FSM state and pending destination registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pend_dest_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            pend_dest_q <= pend_dest_d;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_dest_q[0] <= 4'd0;
            fifo_dest_q[1] <= 4'd0;
            fifo_data_q[0] <= 8'd0;
            fifo_data_q[1] <= 8'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            if (push) begin
                fifo_dest_q[wr_ptr_q] <= alu_dest;
                fifo_data_q[wr_ptr_q] <= alu_data;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Registered write port and sticky error flag; index/data hold when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_q <= 1'b0;
            dest_q      <= 4'd0;
            data_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            reg_write_q <= wr_en;
            if (wr_en) begin
                dest_q <= wr_dest;
                data_q <= wr_data;
            end
            if ((state_q == StIdle) && mem_rvalid) err_q <= 1'b1;
        end
    end

    assign RegWrite    = reg_write_q;
    assign destination = dest_q;
    assign write_data  = data_q;
    assign err         = err_q;

endmodule
